stage_sequencer: RTL and testbench
==================================

# stage_sequencer

Drives the one-hot stage vector of the multi-cycle core: decides, every clock, which pipeline stage is active next. Each stage's datapath reports completion through a per-stage ready line. The sequencer advances, skips, flushes or halts the active stage and publishes it one-hot, as a binary index and as entry pulses. It is the producer of the stage vector that the stage-holding register and all stage-gated control logic consume. It also owns the per-stage watchdog and the retired-instruction counter.

## Interface
- NUM_STAGES, 5, number of stages; stage 0 is fetch; minimum 2
- RESET_STAGE, 0, stage index active after reset and after flush
- MAX_WAIT, 255, consecutive not-ready cycles tolerated in one stage; 0 disables the watchdog
- CNT_WIDTH, 16, width of the retired-instruction counter
- clk  in  1  clock, rising edge
- clear  in  1  reset, synchronous, active-high
- run  in  1  1 = sequencer may advance; 0 = hold current stage
- flush  in  1  return to RESET_STAGE on next edge
- stage_ready  in  NUM_STAGES  per-stage completion; only the bit of the active stage is examined
- skip  in  NUM_STAGES  per-stage bypass request, sampled when advancing into that stage
- stage  out  NUM_STAGES  one-hot active stage
- stage_idx  out  $clog2(NUM_STAGES)  binary index of the active stage
- stage_first  out  1  high on the first cycle of any stage occupancy
- instr_done  out  1  one-cycle pulse on the first cycle after wrapping from the last stage to stage 0
- timeout  out  1  sticky watchdog fault
- retire_count  out  CNT_WIDTH  number of wraps to stage 0 since clear, modulo 2^CNT_WIDTH

## Operation
- Control states:
  - RUN: normal operation.
  - FAULT: entered on watchdog expiry; left only by clear.
- Per-edge priority: clear > FAULT hold > flush > !run hold > advance > wait.
- clear:
  - stage = 1<<RESET_STAGE, stage_first=1.
  - instr_done=0, timeout=0, retire_count=0, wait_cnt=0.
  - State returns to RUN.
- flush: stage = RESET_STAGE, stage_first=1, wait_cnt=0. Does not count as a retire; instr_done=0.
- Hold (run=0): stage unchanged, stage_first=0, wait_cnt unchanged.
- Advance (run=1 and stage_ready[idx]=1):
  - nxt = (idx+1) mod NUM_STAGES.
  - If skip[nxt]=1 and nxt≠0, go to (nxt+1) mod NUM_STAGES. At most one stage is skipped per advance. skip[0] is ignored.
  - wait_cnt is cleared and stage_first=1.
  - If the target index is 0, the transition is a wrap: retire_count increments with modulo wrap, and instr_done=1 on the following cycle.
- Wait (run=1, stage_ready[idx]=0): wait_cnt increments and stage_first=0.
  - If MAX_WAIT≠0 and wait_cnt==MAX_WAIT-1 at the edge: enter FAULT, timeout=1, stage forced to RESET_STAGE.
- In FAULT:
  - stage is held at RESET_STAGE, stage_first=0, instr_done=0.
  - All inputs except clear are ignored.
- Invariant: stage has exactly one bit set and agrees with stage_idx in every cycle.

## Timing
- All outputs are registered. No combinational path exists from any input to any output.
- Reset values: stage=1<<RESET_STAGE, stage_idx=RESET_STAGE, stage_first=1, instr_done=0, timeout=0, retire_count=0.
- Latency: ready sampled high at edge N gives the new stage visible after edge N. A stage with ready tied high therefore occupies exactly 1 cycle.
- One instruction with all stages ready and no skips takes NUM_STAGES cycles. instr_done pulses on the first fetch cycle of the next instruction.
- Watchdog: MAX_WAIT consecutive run=1, not-ready cycles in a stage. timeout=1 from the cycle after the MAX_WAIT-th such cycle.
  - run=0 cycles neither count nor reset wait_cnt.
- Simultaneous events:
  - flush with ready: flush wins and no retire is counted.
  - flush on the same edge as watchdog expiry: flush wins and wait_cnt is cleared.
  - clear during FAULT or mid-stage: reset values on the next cycle.
- Wrap with a skip of the last stage (skip[NUM_STAGES-1] while advancing from NUM_STAGES-2): target is 0 and counts as a retire.
- retire_count at 2^CNT_WIDTH-1 plus one retire gives 0. No flag is raised.

## Test plan
- Reset then run=1, stage_ready all 1, no skip, NUM_STAGES=5: stage_idx sequence 0,1,2,3,4,0,1. instr_done high only at the 2nd cycle of idx 0. retire_count=1 after the first wrap.
- skip[3]=1 with all ready: sequence 0,1,2,4,0. retire_count increments per wrap and each instruction takes 4 cycles. skip[0]=1 has no effect.
- stage_ready[2]=0 for 10 cycles with MAX_WAIT=255: idx held at 2, stage_first=0 after entry. Advance to 3 on the cycle after ready rises. timeout stays 0.
- MAX_WAIT=4, stage_ready[1] stuck 0: timeout=1 and idx=RESET_STAGE after 4 waiting cycles. idx stays there despite ready, flush and run until clear. clear restores all reset values.
- flush in stage 3 together with stage_ready[3]=1: next idx=0, instr_done=0, retire_count unchanged. run=0 for 3 cycles mid-stage leaves idx and wait_cnt unchanged.
- CNT_WIDTH=4: 16 full instructions make retire_count wrap 15→0. The one-hot check holds every cycle.

Source files
------------

// File: rtl/stage_sequencer.sv
// stage_sequencer: selects the active pipeline stage every clock and
// publishes it one-hot, as a binary index and as entry pulses. Also owns the
// per-stage watchdog and the retired-instruction counter.
module stage_sequencer #(
  parameter int NUM_STAGES  = 5,
  parameter int RESET_STAGE = 0,
  parameter int MAX_WAIT    = 255,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          clear,
  input  logic                          run,
  input  logic                          flush,
  input  logic [NUM_STAGES-1:0]         stage_ready,
  input  logic [NUM_STAGES-1:0]         skip,
  output logic [NUM_STAGES-1:0]         stage,
  output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
  output logic                          stage_first,
  output logic                          instr_done,
  output logic                          timeout,
  output logic [CNT_WIDTH-1:0]          retire_count
);

  localparam int IW = $clog2(NUM_STAGES);
  // wait_cnt only has to reach MAX_WAIT-1 before the fault fires
  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [IW-1:0] RST_IDX  = IW'(RESET_STAGE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_STAGES - 1);
  localparam logic [WW-1:0] WLAST    = WW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
  localparam bit            WD_EN    = (MAX_WAIT != 0);

  typedef enum logic {S_RUN, S_FAULT} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NUM_STAGES-1:0]   stage_q, stage_d;
  logic                    first_q, first_d;
  logic                    done_q, done_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]           wait_q, wait_d;
  logic [IW-1:0]           nxt, tgt;

  // Successor stage, with at most one bypassed stage (fetch is never bypassed)
  always_comb begin
    nxt = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    tgt = nxt;
    if (nxt != '0 && skip[nxt])
      tgt = (nxt == LAST_IDX) ? '0 : nxt + 1'b1;
  end

  // Next-state: clear is handled in the register; here FAULT > flush > hold > advance > wait
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    first_d = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    case (state_q)
      S_FAULT: idx_d = RST_IDX;
      default: begin
        if (flush) begin
          idx_d   = RST_IDX;
          first_d = 1'b1;
          wait_d  = '0;
        end else if (!run) begin
          // hold: stage and wait_cnt frozen
        end else if (stage_ready[idx_q]) begin
          idx_d   = tgt;
          first_d = 1'b1;
          wait_d  = '0;
          if (tgt == '0) begin
            done_d = 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end
        end else if (WD_EN && wait_q == WLAST) begin
          state_d = S_FAULT;
          idx_d   = RST_IDX;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
    endcase
    stage_d = NUM_STAGES'(1) << idx_d;
  end

  // State and output registers; every output comes straight from a flop
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_RUN;
      idx_q   <= RST_IDX;
      stage_q <= NUM_STAGES'(1) << RST_IDX;
      first_q <= 1'b1;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      first_q <= first_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  assign stage        = stage_q;
  assign stage_idx    = idx_q;
  assign stage_first  = first_q;
  assign instr_done   = done_q;
  assign timeout      = (state_q == S_FAULT);
  assign retire_count = cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed vectors, an integer-level reference
// model compared every cycle, plus literal expectations at key points.
// Watchdog limit of 12 and a 4-bit counter keep the fault and wrap cases short.
module tb_stage_sequencer;
  localparam int N  = 5;
  localparam int RS = 0;
  localparam int MW = 12;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clear, run, flush;
  logic [N-1:0]  stage_ready, skip;
  logic [N-1:0]  stage;
  logic [2:0]    stage_idx;
  logic          stage_first, instr_done, timeout;
  logic [CW-1:0] retire_count;

  int checks = 0, failures = 0;
  bit chk_en = 0;

  // model state
  int m_idx, m_wait, m_cnt;
  bit m_first, m_done, m_fault;

  stage_sequencer #(.NUM_STAGES(N), .RESET_STAGE(RS), .MAX_WAIT(MW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .clear(clear), .run(run), .flush(flush),
    .stage_ready(stage_ready), .skip(skip), .stage(stage), .stage_idx(stage_idx),
    .stage_first(stage_first), .instr_done(instr_done), .timeout(timeout),
    .retire_count(retire_count));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: applies the per-edge priority rules directly
  always @(posedge clk) begin
    int t;
    if (clear) begin
      m_idx = RS; m_first = 1; m_done = 0; m_fault = 0; m_cnt = 0; m_wait = 0;
    end else if (m_fault) begin
      m_idx = RS; m_first = 0; m_done = 0;
    end else if (flush) begin
      m_idx = RS; m_first = 1; m_done = 0; m_wait = 0;
    end else if (!run) begin
      m_first = 0; m_done = 0;
    end else if (stage_ready[m_idx]) begin
      t = (m_idx + 1) % N;
      if (t != 0 && skip[t]) t = (t + 1) % N;
      m_done = (t == 0);
      if (t == 0) m_cnt = (m_cnt + 1) % (1 << CW);
      m_idx = t; m_first = 1; m_wait = 0;
    end else begin
      m_wait++; m_first = 0; m_done = 0;
      if (m_wait == MW) begin
        m_fault = 1; m_idx = RS; m_wait = 0;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("onehot", $countones(stage), 1);
      chk("stage", int'(stage), 1 << m_idx);
      chk("stage_idx", int'(stage_idx), m_idx);
      chk("stage_first", int'(stage_first), int'(m_first));
      chk("instr_done", int'(instr_done), int'(m_done));
      chk("timeout", int'(timeout), int'(m_fault));
      chk("retire_count", int'(retire_count), m_cnt);
    end
  end

  task automatic step(input bit r, input bit f, input logic [N-1:0] rdy,
                      input logic [N-1:0] sk, input int n = 1);
    run = r; flush = f; stage_ready = rdy; skip = sk;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    clear = 1; run = 0; flush = 0; stage_ready = '0; skip = '0;
    @(posedge clk); #1;
    clear = 0; chk_en = 1;
    chk("rst_idx", stage_idx, 0); chk("rst_first", stage_first, 1);
    chk("rst_to", timeout, 0); chk("rst_cnt", retire_count, 0);

    // plain sequence 0,1,2,3,4,0,1
    step(1, 0, 5'b11111, 5'b00000, 4);
    chk("seq_idx4", stage_idx, 4); chk("seq_done_pre", instr_done, 0);
    step(1, 0, 5'b11111, 5'b00000);
    chk("wrap_idx", stage_idx, 0); chk("wrap_done", instr_done, 1);
    chk("wrap_cnt", retire_count, 1);
    step(1, 0, 5'b11111, 5'b00000);
    chk("post_idx", stage_idx, 1); chk("post_done", instr_done, 0);
    step(1, 0, 5'b11111, 5'b00000, 4);          // 2,3,4,0
    chk("cnt2", retire_count, 2);

    // skip[3] (skip[0] ignored): 0,1,2,4,0 -> 4 cycles
    step(1, 0, 5'b11111, 5'b01001, 3);
    chk("skip_idx", stage_idx, 4);
    step(1, 0, 5'b11111, 5'b01001);
    chk("skip_wrap", stage_idx, 0); chk("skip_cnt", retire_count, 3);

    // skip of last stage wraps from stage 3
    step(1, 0, 5'b11111, 5'b10000, 4);
    chk("skiplast_idx", stage_idx, 0); chk("skiplast_cnt", retire_count, 4);
    chk("skiplast_done", instr_done, 1);

    // stage 2 waits 10 cycles, then advances
    step(1, 0, 5'b11111, 5'b00000, 2);
    step(1, 0, 5'b11011, 5'b00000, 10);
    chk("wait_idx", stage_idx, 2); chk("wait_first", stage_first, 0);
    chk("wait_to", timeout, 0);
    step(1, 0, 5'b11111, 5'b00000);
    chk("wait_adv", stage_idx, 3); chk("wait_adv_first", stage_first, 1);
    step(1, 0, 5'b11111, 5'b00000, 2);
    chk("cnt5", retire_count, 5);

    // flush with ready in stage 3: no retire
    step(1, 0, 5'b11111, 5'b00000, 3);
    chk("pre_flush", stage_idx, 3);
    step(1, 1, 5'b11111, 5'b00000);
    chk("flush_idx", stage_idx, 0); chk("flush_done", instr_done, 0);
    chk("flush_cnt", retire_count, 5);

    // flush on the watchdog-expiry edge wins
    step(1, 0, 5'b11111, 5'b00000);
    step(1, 0, 5'b00000, 5'b00000, MW - 1);
    chk("pre_exp_to", timeout, 0);
    step(1, 1, 5'b00000, 5'b00000);
    chk("flushexp_idx", stage_idx, 0); chk("flushexp_to", timeout, 0);

    // run=0 holds stage and does not reset wait_cnt; then watchdog fires
    step(1, 0, 5'b11111, 5'b00000);
    step(1, 0, 5'b00000, 5'b00000, 3);
    step(0, 0, 5'b11111, 5'b00000, 3);
    chk("hold_idx", stage_idx, 1); chk("hold_first", stage_first, 0);
    step(1, 0, 5'b00000, 5'b00000, MW - 4);
    chk("wd_pre_to", timeout, 0); chk("wd_pre_idx", stage_idx, 1);
    step(1, 0, 5'b00000, 5'b00000);
    chk("wd_to", timeout, 1); chk("wd_idx", stage_idx, RS);

    // FAULT ignores ready, flush and run
    step(1, 1, 5'b11111, 5'b11111, 3);
    step(1, 0, 5'b11111, 5'b00000, 3);
    chk("fault_idx", stage_idx, RS); chk("fault_to", timeout, 1);
    chk("fault_first", stage_first, 0);

    // clear restores reset values
    clear = 1; step(0, 0, 5'b00000, 5'b00000); clear = 0;
    chk("clr_to", timeout, 0); chk("clr_first", stage_first, 1);
    chk("clr_cnt", retire_count, 0); chk("clr_idx", stage_idx, RS);

    // 16 instructions wrap the 4-bit counter 15 -> 0
    step(1, 0, 5'b11111, 5'b00000, 75);
    chk("cnt15", retire_count, 15);
    step(1, 0, 5'b11111, 5'b00000, 5);
    chk("cnt_wrap", retire_count, 0); chk("cnt_wrap_done", instr_done, 1);

    // clear mid-stage
    step(1, 0, 5'b11111, 5'b00000, 2);
    clear = 1; step(1, 0, 5'b11111, 5'b00000); clear = 0;
    chk("clr_mid_idx", stage_idx, RS);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
